// File: rtl/alu_sequencer.sv
// alu_sequencer: runs a short program of accumulator ALU instructions held in a small writable program memory.
module alu_sequencer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH+2:0] wr_data_i,
  input  logic             start_i,
  input  logic [AW:0]      prog_len_i,
  input  logic [WIDTH-1:0] init_val_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_gt_zero_o,
  output logic             flag_zero_o,
  output logic             flag_carry_o,
  output logic             busy_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [WIDTH+2:0] mem_q [DEPTH];
  logic [WIDTH-1:0] acc_q, acc_d, alu_res, b;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic carry_q, carry_d, alu_c;
  logic [2:0] op;
  logic [WIDTH:0] sum, dif;
  assign {op, b} = mem_q[pc_q];
  assign sum = {1'b0, acc_q} + {1'b0, b};
  assign dif = {1'b0, acc_q} - {1'b0, b};
  always_comb begin
    alu_res = b;
    alu_c = 1'b0;
    case (op)
      3'd0: {alu_c, alu_res} = sum;
      3'd1: {alu_c, alu_res} = dif;
      3'd2: alu_res = acc_q & b;
      3'd3: alu_res = acc_q | b;
      3'd4: alu_res = acc_q ^ b;
      3'd5: {alu_c, alu_res} = {acc_q, 1'b0};
      3'd6: {alu_res, alu_c} = {1'b0, acc_q};
      default: alu_res = b;
    endcase
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    pc_d = pc_q;
    len_d = len_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (start_i) begin
        acc_d = init_val_i;
        pc_d = '0;
        len_d = prog_len_i > DEPTH_L ? DEPTH_L : prog_len_i;
        carry_d = 1'b0;
        state_d = prog_len_i == '0 ? DONE : EXEC;
      end
      EXEC: begin
        acc_d = alu_res;
        carry_d = alu_c;
        pc_d = pc_q + 1'b1;
        state_d = {1'b0, pc_q} == len_q - 1'b1 ? DONE : EXEC;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      acc_q <= '0;
      pc_q <= '0;
      len_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      pc_q <= pc_d;
      len_q <= len_d;
      carry_q <= carry_d;
    end
  // Program memory only accepts writes while idle so a running program never changes under itself.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && state_q == IDLE && {1'b0, wr_addr_i} < DEPTH_L) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  assign result_o = acc_q;
  assign flag_zero_o = acc_q == '0;
  assign flag_gt_zero_o = !acc_q[WIDTH-1] && acc_q != '0;
  assign flag_carry_o = carry_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, corner sequences and randomized programs against a behavioural model.
module tb_alu_sequencer;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] prog_len = '0;
  logic [4:0] init_val = '0;
  logic [4:0] result;
  logic gt, zero, carry, busy, done;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [8];
  typedef struct packed {
    logic [63:0] prog;
    logic [3:0] plen;
    logic [4:0] init;
    logic [4:0] res;
    logic z, g, c;
  } vec_t;
  vec_t vecs [8];
  alu_sequencer #(.WIDTH(5), .DEPTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_i(start), .prog_len_i(prog_len), .init_val_i(init_val), .result_o(result),
    .flag_gt_zero_o(gt), .flag_zero_o(zero), .flag_carry_o(carry), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic write_mem(int a, logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    mem_m[a] = d;
  endtask
  function automatic void model(int plen, int init, output int res, output int c);
    int a = init, b, op;
    c = 0;
    for (int i = 0; i < (plen > 8 ? 8 : plen); i++) begin
      op = mem_m[i] / 32;
      b = mem_m[i] % 32;
      case (op)
        0: begin c = (a + b) >= 32; a = (a + b) % 32; end
        1: begin c = a < b; a = (a - b + 32) % 32; end
        2: begin a = a & b; c = 0; end
        3: begin a = a | b; c = 0; end
        4: begin a = a ^ b; c = 0; end
        5: begin c = a >= 16; a = (a * 2) % 32; end
        6: begin c = a % 2; a = a / 2; end
        default: begin a = b; c = 0; end
      endcase
    end
    res = a;
  endfunction
  task automatic run(string tag, int plen, int init, int res, int z, int g, int c);
    int cnt = 0;
    start = 1'b1;
    prog_len = 4'(plen);
    init_val = 5'(init);
    step();
    start = 1'b0;
    while (!done && cnt < 40) begin
      step();
      cnt++;
    end
    chk({tag, " latency"}, cnt, plen > 8 ? 8 : plen);
    chk({tag, " result"}, result, res);
    chk({tag, " zero"}, zero, z);
    chk({tag, " gt_zero"}, gt, g);
    chk({tag, " carry"}, carry, c);
    chk({tag, " busy in done"}, busy, 1);
    step();
    chk({tag, " done one cycle"}, done, 0);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " result held"}, result, res);
    chk({tag, " carry held"}, carry, c);
  endtask
  initial begin
    int r, c, hits;
    vecs[0] = '{prog: 64'h0000_0000_00A0_2204, plen: 3, init: 3, res: 10, z: 0, g: 1, c: 0};
    vecs[1] = '{prog: 64'h01, plen: 1, init: 31, res: 0, z: 1, g: 0, c: 1};
    vecs[2] = '{prog: 64'h21, plen: 1, init: 0, res: 31, z: 0, g: 0, c: 1};
    vecs[3] = '{prog: 64'h0, plen: 0, init: 7, res: 7, z: 0, g: 1, c: 0};
    vecs[4] = '{prog: 64'h0101_0101_0101_0101, plen: 12, init: 0, res: 8, z: 0, g: 1, c: 0};
    vecs[5] = '{prog: 64'h0000_00C0_9F6C_43E5, plen: 5, init: 0, res: 9, z: 0, g: 1, c: 0};
    vecs[6] = '{prog: 64'hC0, plen: 1, init: 3, res: 1, z: 0, g: 1, c: 1};
    vecs[7] = '{prog: 64'hA0, plen: 1, init: 20, res: 8, z: 0, g: 1, c: 1};
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    #1;
    chk("reset result", result, 0);
    chk("reset zero", zero, 1);
    chk("reset gt_zero", gt, 0);
    chk("reset carry", carry, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    step();
    reset = 1'b0;
    step();
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 8; i++) write_mem(i, vecs[v].prog[8*i +: 8]);
      run($sformatf("vec%0d", v), vecs[v].plen, vecs[v].init, vecs[v].res, vecs[v].z, vecs[v].g, vecs[v].c);
    end
    // busy-time write and start must both be ignored
    for (int i = 0; i < 8; i++) write_mem(i, 8'h01);
    start = 1'b1;
    prog_len = 4'd8;
    init_val = 5'd0;
    step();
    start = 1'b0;
    step();
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'hFF;
    start = 1'b1;
    init_val = 5'd20;
    prog_len = 4'd1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    hits = 0;
    while (!done && hits < 40) begin
      step();
      hits++;
    end
    chk("busy run latency", hits + 2, 8);
    chk("busy run result", result, 8);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hits += int'(done) + int'(busy);
    end
    chk("no restart", hits, 0);
    chk("no restart result", result, 8);
    run("mem unchanged", 1, 0, 1, 0, 1, 0);
    // same-edge write and start
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'hE9;
    mem_m[0] = 8'hE9;
    run("same edge", 1, 0, 9, 0, 1, 0);
    wr_en = 1'b0;
    // asynchronous reset mid-run
    for (int i = 0; i < 8; i++) write_mem(i, 8'h23);
    start = 1'b1;
    prog_len = 4'd8;
    init_val = 5'd30;
    step();
    start = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk("async result", result, 0);
    chk("async zero", zero, 1);
    chk("async gt_zero", gt, 0);
    chk("async carry", carry, 0);
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      hits += int'(done);
    end
    chk("aborted no done", hits, 0);
    run("mem cleared", 8, 5, 5, 0, 1, 0);
    for (int t = 0; t < 30; t++) begin
      int plen, init;
      for (int i = 0; i < 8; i++) write_mem(i, 8'($urandom));
      plen = $urandom_range(0, 15);
      init = $urandom_range(0, 31);
      model(plen, init, r, c);
      run($sformatf("rand%0d", t), plen, init, r, r == 0, r > 0 && r < 16, c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 5, operand/accumulator/result width in bits (legal 2..32).
REQ-002 Parameter DEPTH, default 8, program-memory entries (legal 2..64); AW = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  program-memory write strobe.
REQ-006 wr_addr  input  AW  program-memory write address.
REQ-007 wr_data  input  3+WIDTH  instruction {OP[2:0], B[WIDTH-1:0]}.
REQ-008 start  input  1  begin program execution.
REQ-009 prog_len  input  AW+1  number of instructions to run.
REQ-010 init_val  input  WIDTH  initial accumulator value.
REQ-011 result  output  WIDTH  accumulator value.
REQ-012 flag_gt_zero  output  1  result > 0, two's-complement signed.
REQ-013 flag_zero  output  1  result == 0.
REQ-014 flag_carry  output  1  carry/borrow/shift-out of last executed instruction.
REQ-015 busy  output  1  high in EXEC and DONE states.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, EXEC, DONE; outputs busy/done decoded from the state register.
REQ-018 IDLE: start=1 -> EXEC; acc <= init_val; pc <= 0; len <= min(prog_len, DEPTH); flag_carry <= 0.
REQ-019 IDLE with start=1 and prog_len=0 -> DONE directly; acc <= init_val, no instruction executed.
REQ-020 EXEC: each edge executes mem[pc]: acc <= alu(acc, B); pc <= pc+1; flag_carry updated.
REQ-021 EXEC -> DONE on the edge executing pc == len-1; otherwise remain in EXEC.
REQ-022 DONE: done=1 for exactly one cycle; unconditional transition DONE -> IDLE.
REQ-023 Latency: for len=N>=1, done is high in the cycle following the Nth edge after the edge that sampled start.
REQ-024 OP 000 ADD: acc+B mod 2^WIDTH; carry = bit WIDTH of the sum.
REQ-025 OP 001 SUB: acc-B mod 2^WIDTH; carry = borrow (1 when acc < B unsigned).
REQ-026 OP 010 AND, 011 OR, 100 XOR: bitwise; carry = 0.
REQ-027 OP 101 SHL: acc<<1, LSB 0; carry = old acc MSB.
REQ-028 OP 110 SHR: logical acc>>1, MSB 0; carry = old acc LSB.
REQ-029 OP 111 LOAD: acc <= B; carry = 0.
REQ-030 result = acc register; flag_zero, flag_gt_zero combinational from acc.
REQ-031 result and all flags are held stable from done until the next accepted start.
REQ-032 Writes are accepted only in IDLE; wr_en while busy is ignored and memory is unchanged.
REQ-033 start is ignored while busy; no re-trigger or restart.
REQ-034 Same-edge wr_en and start in IDLE: the write completes and start is accepted; the written entry is visible to execution from that point onward.

Reset
REQ-035 reset=1 immediately forces state IDLE, acc=0, pc=0, len=0, and flag_carry=0, independent of clk.
REQ-036 During reset: result=0, flag_zero=1, flag_gt_zero=0, flag_carry=0, busy=0, done=0.
REQ-037 Reset clears every program-memory entry to 0 (ADD 0, a no-op).
REQ-038 Reset asserted mid-EXEC aborts the run; no done pulse is produced for that run.

Verification (WIDTH=5, DEPTH=8)
REQ-039 Program {ADD 4, SUB 2, SHL}, init_val=3, prog_len=3 -> done high in the cycle after the 3rd edge following start; result=01010, gt_zero=1, zero=0, carry=0.
REQ-040 Program {ADD 1}, init_val=31, prog_len=1 -> result=0, zero=1, gt_zero=0, carry=1.
REQ-041 Program {SUB 1}, init_val=0, prog_len=1 -> result=11111, gt_zero=0, zero=0, carry=1.
REQ-042 prog_len=0, init_val=7 -> done in the cycle after the start edge; result=7; prog_len=12 -> exactly 8 instructions execute.
REQ-043 While busy: pulse wr_en on addr 0 and pulse start -> memory is unchanged and no second run occurs; then reset asserted mid-EXEC -> all outputs return to reset values asynchronously and no done pulse is produced.
